pipe_reg_chain: RTL and testbench

- Parametrised successor to simple_pipe_reg: a valid/ready register slice chained REG_LENGTH deep, with REG_TYPE selecting the stage style.
- Adds a synchronous flush, so a core reset can drain in-flight words without touching the global reset, and a live occupancy count.
- Sits on every core-boundary channel of the RISC-V block wrappers (DMA, descriptors, broadcast messages, status). It is used for timing closure across the partial-reconfiguration boundary.

---
 rtl/pipe_reg_chain_pkg.sv | 13 +
 rtl/pipe_reg_stage.sv | 93 +++++++++
 rtl/pipe_reg_chain.sv | 82 ++++++++
 tb/tb_pipe_reg_chain.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_chain_pkg.sv
// Shared encodings and sizing helpers for the pipe_reg_chain register slice.
package pipe_reg_chain_pkg;

    localparam int PIPE_WIRE   = 0;
    localparam int PIPE_SIMPLE = 1;
    localparam int PIPE_SKID   = 2;

    // Occupancy must be able to represent a completely full skid chain.
    function automatic int occ_width(input int reg_length);
        return $clog2(2 * reg_length + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One valid/ready slice: simple register (combinational ready) or skid buffer (registered ready).
module pipe_reg_stage
    import pipe_reg_chain_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int REG_TYPE   = PIPE_SKID
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [1:0]            count_d_o
);

    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  valid_q;
    logic                  valid_d;
    logic                  skid_v_q;
    logic                  skid_v_d;
    logic                  in_xfer;
    logic                  out_xfer;
    logic                  load_main_in;
    logic                  load_main_skid;
    logic                  load_skid;

    if (REG_TYPE == PIPE_SKID) begin : g_skid_ready
        assign s_ready_o = !skid_v_q;
    end else begin : g_simple_ready
        assign s_ready_o = !valid_q || m_ready_i;
    end

    assign m_data_o  = data_q;
    assign m_valid_o = valid_q;
    assign count_d_o = {1'b0, valid_d} + {1'b0, skid_v_d};

    // The "into skid" branch is only reachable in skid mode: a simple stage
    // only accepts while full when its word is being taken in the same cycle.
    always_comb begin
        in_xfer        = s_valid_i && s_ready_o;
        out_xfer       = valid_q && m_ready_i;
        valid_d        = valid_q;
        skid_v_d       = skid_v_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush_i) begin
            valid_d  = 1'b0;
            skid_v_d = 1'b0;
        end else if (out_xfer && skid_v_q) begin
            load_main_skid = 1'b1;
            valid_d        = 1'b1;
            load_skid      = in_xfer;
            skid_v_d       = in_xfer;
        end else if (in_xfer && valid_q && !out_xfer) begin
            load_skid = 1'b1;
            skid_v_d  = 1'b1;
        end else if (in_xfer) begin
            load_main_in = 1'b1;
            valid_d      = 1'b1;
        end else if (out_xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            skid_v_q <= skid_v_d;
        end
    end

    // Payload registers carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (load_main_in) begin
            data_q <= s_data_i;
        end else if (load_main_skid) begin
            data_q <= skid_q;
        end
        if (load_skid) begin
            skid_q <= s_data_i;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Chain of REG_LENGTH valid/ready slices with synchronous flush and a live occupancy count.
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int REG_TYPE   = PIPE_SKID,
    parameter int REG_LENGTH = 1,
    parameter int OCC_WIDTH  = occ_width(REG_LENGTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [OCC_WIDTH-1:0]  occupancy
);

    logic [OCC_WIDTH-1:0] occ_d;
    logic [OCC_WIDTH-1:0] occ_q;

    if (REG_TYPE == PIPE_WIRE) begin : g_wire
        assign m_data  = s_data;
        assign m_valid = s_valid && !flush;
        assign s_ready = m_ready && !flush;
        assign occ_d   = '0;
    end else begin : g_chain
        logic [REG_LENGTH:0][DATA_WIDTH-1:0] link_data;
        logic [REG_LENGTH:0]                 link_valid;
        logic [REG_LENGTH:0]                 link_ready;
        logic [REG_LENGTH-1:0][1:0]          stage_cnt;

        // Flush blocks both boundary handshakes so nothing moves in or out
        // during the cycle the stages are being emptied.
        assign link_data[0]           = s_data;
        assign link_valid[0]          = s_valid && !flush;
        assign s_ready                = link_ready[0] && !flush;
        assign m_data                 = link_data[REG_LENGTH];
        assign m_valid                = link_valid[REG_LENGTH] && !flush;
        assign link_ready[REG_LENGTH] = m_ready && !flush;

        for (genvar k = 0; k < REG_LENGTH; k++) begin : g_stage
            pipe_reg_stage #(
                .DATA_WIDTH (DATA_WIDTH),
                .REG_TYPE   (REG_TYPE)
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .flush_i    (flush),
                .s_data_i   (link_data[k]),
                .s_valid_i  (link_valid[k]),
                .s_ready_o  (link_ready[k]),
                .m_data_o   (link_data[k+1]),
                .m_valid_o  (link_valid[k+1]),
                .m_ready_i  (link_ready[k+1]),
                .count_d_o  (stage_cnt[k])
            );
        end

        always_comb begin
            occ_d = '0;
            for (int k = 0; k < REG_LENGTH; k++) begin
                occ_d = occ_d + OCC_WIDTH'(stage_cnt[k]);
            end
        end
    end

    // Summing next-state bits keeps the count aligned with the valid flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain in skid (len 3), simple (len 2) and wire-through configurations.
module tb_pipe_reg_chain;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // skid, length 3
    logic        rst2, t2_flush, t2_s_valid, t2_s_ready, t2_m_valid, t2_m_ready;
    logic [31:0] t2_s_data, t2_m_data;
    logic [2:0]  t2_occ;
    // simple, length 2
    logic        rst1, t1_flush, t1_s_valid, t1_s_ready, t1_m_valid, t1_m_ready;
    logic [31:0] t1_s_data, t1_m_data;
    logic [2:0]  t1_occ;
    // wire-through
    logic        rst0, t0_flush, t0_s_valid, t0_s_ready, t0_m_valid, t0_m_ready;
    logic [31:0] t0_s_data, t0_m_data;
    logic [1:0]  t0_occ;

    logic [31:0] exp2_q[$];
    logic [31:0] exp1_q[$];
    logic [31:0] exp0_q[$];

    int t2_first_in = 0;
    int t2_first_out = 0;
    int t2_gaps = 0;
    bit t2_gap_en = 0;
    bit t1_en = 0;
    bit m1_v0 = 0;
    bit m1_v1 = 0;

    pipe_reg_chain #(.DATA_WIDTH(32), .REG_TYPE(2), .REG_LENGTH(3)) u_dut2 (
        .clk(clk), .rst(rst2), .flush(t2_flush), .s_data(t2_s_data), .s_valid(t2_s_valid),
        .s_ready(t2_s_ready), .m_data(t2_m_data), .m_valid(t2_m_valid), .m_ready(t2_m_ready),
        .occupancy(t2_occ));

    pipe_reg_chain #(.DATA_WIDTH(32), .REG_TYPE(1), .REG_LENGTH(2)) u_dut1 (
        .clk(clk), .rst(rst1), .flush(t1_flush), .s_data(t1_s_data), .s_valid(t1_s_valid),
        .s_ready(t1_s_ready), .m_data(t1_m_data), .m_valid(t1_m_valid), .m_ready(t1_m_ready),
        .occupancy(t1_occ));

    pipe_reg_chain #(.DATA_WIDTH(32), .REG_TYPE(0), .REG_LENGTH(1)) u_dut0 (
        .clk(clk), .rst(rst0), .flush(t0_flush), .s_data(t0_s_data), .s_valid(t0_s_valid),
        .s_ready(t0_s_ready), .m_data(t0_m_data), .m_valid(t0_m_valid), .m_ready(t0_m_ready),
        .occupancy(t0_occ));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitors (run at negedge) ----------------
    task automatic mon2();
        if (t2_first_out < 0 && t2_m_valid) t2_first_out = cyc;
        check("t2_occ_max", {63'd0, t2_occ > 3'd6}, 64'd0);
        if (t2_gap_en && t2_m_ready && !t2_m_valid && exp2_q.size() != 0) t2_gaps++;
        if (t2_m_valid && t2_m_ready) begin
            if (exp2_q.size() == 0) check("t2_spurious_out", 64'd1, 64'd0);
            else check("t2_data", t2_m_data, exp2_q.pop_front());
        end
    endtask

    task automatic mon1();
        bit r0, r1, n0, n1;
        if (t1_en) begin
            r1 = !m1_v1 || t1_m_ready;
            r0 = !m1_v0 || r1;
            check("t1_s_ready", t1_s_ready, r0);
            check("t1_m_valid", t1_m_valid, m1_v1);
            check("t1_occ", t1_occ, 3'(m1_v0) + 3'(m1_v1));
            n1 = (m1_v0 && r1) ? 1'b1 : ((m1_v1 && t1_m_ready) ? 1'b0 : m1_v1);
            n0 = (t1_s_valid && r0) ? 1'b1 : ((m1_v0 && r1) ? 1'b0 : m1_v0);
            m1_v0 = n0;
            m1_v1 = n1;
        end
        if (t1_m_valid && t1_m_ready) begin
            if (exp1_q.size() == 0) check("t1_spurious_out", 64'd1, 64'd0);
            else check("t1_data", t1_m_data, exp1_q.pop_front());
        end
    endtask

    task automatic mon0();
        check("t0_m_valid", t0_m_valid, t0_s_valid && !t0_flush);
        check("t0_s_ready", t0_s_ready, t0_m_ready && !t0_flush);
        check("t0_m_data", t0_m_data, t0_s_data);
        check("t0_occ", t0_occ, 2'd0);
        if (t0_m_valid && t0_m_ready) begin
            if (exp0_q.size() == 0) check("t0_spurious_out", 64'd1, 64'd0);
            else check("t0_data", t0_m_data, exp0_q.pop_front());
        end
    endtask

    // ---------------- drivers (enter and leave at posedge+1) ----------------
    task automatic send2(input logic [31:0] w);
        int tries = 0;
        bit done = 0;
        t2_s_data  = w;
        t2_s_valid = 1'b1;
        while (!done && tries < 40) begin
            #1;
            if (t2_s_ready) begin
                exp2_q.push_back(w);
                if (t2_first_in < 0) t2_first_in = cyc;
                done = 1;
            end
            @(posedge clk); #1;
            tries++;
        end
        if (!done) check("t2_send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send1(input logic [31:0] w);
        int tries = 0;
        bit done = 0;
        t1_s_data  = w;
        t1_s_valid = 1'b1;
        while (!done && tries < 40) begin
            #1;
            if (t1_s_ready) begin
                exp1_q.push_back(w);
                done = 1;
            end
            @(posedge clk); #1;
            tries++;
        end
        if (!done) check("t1_send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain2(input int budget);
        int n = 0;
        while (exp2_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("t2_drain", exp2_q.size(), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic drain1(input int budget);
        int n = 0;
        while (exp1_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("t1_drain", exp1_q.size(), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        bit seen_drop;
        rst2 = 1; rst1 = 1; rst0 = 1;
        t2_flush = 0; t2_s_valid = 0; t2_s_data = '0; t2_m_ready = 0;
        t1_flush = 0; t1_s_valid = 0; t1_s_data = '0; t1_m_ready = 0;
        t0_flush = 0; t0_s_valid = 0; t0_s_data = '0; t0_m_ready = 1;

        fork
            forever begin @(negedge clk); mon2(); end
            forever begin @(negedge clk); mon1(); end
            forever begin @(negedge clk); mon0(); end
        join_none

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("t2_rst_m_valid", t2_m_valid, 1'b0);
        check("t2_rst_occ", t2_occ, 3'd0);
        check("t2_rst_s_ready", t2_s_ready, 1'b1);
        check("t1_rst_m_valid", t1_m_valid, 1'b0);
        check("t1_rst_s_ready", t1_s_ready, 1'b1);
        rst2 = 0; rst1 = 0; rst0 = 0;
        t1_en = 1;
        @(posedge clk); #1;

        // ---- skid chain, m_ready=1, 16 back-to-back words ----
        t2_m_ready   = 1;
        t2_first_in  = -1;
        t2_first_out = -1;
        for (int i = 0; i < 16; i++) begin
            send2(32'(i));
            if (i == 7) check("t2_occ_stream", t2_occ, 3'd3);
        end
        t2_s_valid = 0;
        drain2(50);
        check("t2_latency", 64'(t2_first_out - t2_first_in), 64'd3);
        check("t2_occ_idle", t2_occ, 3'd0);

        // ---- skid chain, 8-cycle downstream stall while streaming ----
        t2_m_ready = 0;
        seen_drop  = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) send2(32'h100 + 32'(i));
                t2_s_valid = 0;
            end
            begin
                for (int c = 0; c < 8; c++) begin
                    @(negedge clk);
                    if (!t2_s_ready && !seen_drop) begin
                        seen_drop = 1;
                        check("t2_full_occ", t2_occ, 3'd6);
                        check("t2_captured", exp2_q.size(), 64'd6);
                    end
                end
                check("t2_ready_dropped", {63'd0, seen_drop}, 64'd1);
                @(posedge clk); #1;
                t2_m_ready = 1;
                t2_gap_en  = 1;
            end
        join
        drain2(60);
        t2_gap_en = 0;
        check("t2_no_gap", t2_gaps, 64'd0);

        // ---- flush with four words held ----
        t2_m_ready = 0;
        for (int i = 0; i < 4; i++) send2(32'h200 + 32'(i));
        t2_s_valid = 0;
        check("t2_occ_pre_flush", t2_occ, 3'd4);
        check("t2_m_valid_pre_flush", t2_m_valid, 1'b1);
        t2_flush   = 1;
        t2_s_valid = 1;
        t2_s_data  = 32'hDEAD_BEEF;
        t2_m_ready = 1;
        exp2_q.delete();
        for (int c = 0; c < 2; c++) begin
            #1;
            check("t2_flush_m_valid", t2_m_valid, 1'b0);
            check("t2_flush_s_ready", t2_s_ready, 1'b0);
            @(posedge clk); #1;
            check("t2_flush_occ", t2_occ, 3'd0);
        end
        t2_flush   = 0;
        t2_s_valid = 0;
        #1;
        check("t2_post_flush_m_valid", t2_m_valid, 1'b0);
        @(posedge clk); #1;
        send2(32'h2AA);
        t2_s_valid = 0;
        drain2(20);

        // ---- asynchronous reset mid-stream ----
        t2_m_ready = 0;
        for (int i = 0; i < 4; i++) send2(32'h300 + 32'(i));
        t2_s_valid = 0;
        check("t2_m_valid_pre_rst", t2_m_valid, 1'b1);
        #2;
        rst2 = 1;
        #1;
        check("t2_async_rst_m_valid", t2_m_valid, 1'b0);
        check("t2_async_rst_occ", t2_occ, 3'd0);
        check("t2_async_rst_s_ready", t2_s_ready, 1'b1);
        exp2_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst2 = 0;
        @(negedge clk);
        check("t2_no_spurious_valid", t2_m_valid, 1'b0);
        @(posedge clk); #1;
        t2_m_ready   = 1;
        t2_first_in  = -1;
        t2_first_out = -1;
        send2(32'h3AA);
        t2_s_valid = 0;
        drain2(20);
        check("t2_rst_latency", 64'(t2_first_out - t2_first_in), 64'd3);

        // ---- simple chain, m_ready toggling 1010 ----
        fork
            begin
                for (int c = 0; c < 40; c++) begin
                    t1_m_ready = (c % 2 == 0);
                    @(posedge clk); #1;
                end
                t1_m_ready = 1;
            end
            begin
                #0;
                for (int i = 0; i < 12; i++) send1(32'h500 + 32'(i));
                t1_s_valid = 0;
            end
        join
        drain1(20);
        check("t1_occ_idle", t1_occ, 3'd0);

        // ---- wire-through, random handshakes and occasional flush ----
        for (int c = 0; c < 1000; c++) begin
            t0_s_valid = 1'($urandom_range(0, 1));
            t0_m_ready = 1'($urandom_range(0, 1));
            t0_s_data  = $urandom;
            t0_flush   = ($urandom_range(0, 15) == 0);
            #1;
            if (t0_s_valid && t0_s_ready) exp0_q.push_back(t0_s_data);
            @(posedge clk); #1;
        end
        t0_s_valid = 0;
        t0_flush   = 0;
        @(posedge clk); #1;
        check("t0_no_loss", exp0_q.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
